down_counter_mod: RTL and testbench
===================================

// Module: down_counter_mod
// PURPOSE
//   Loadable, prescaled down-counter. It is the counting-down counterpart of counter_mod,
//   which counts up from reset. A start request captures a preset value. The block then
//   decrements it once every PRESCALE clocks, down to zero, and pulses done when it gets there.
//   The CORDIC datapath uses it to sequence the remaining-iteration count.
// PARAMETERS
//   WIDTH     4  width of the counter value (out, load_val)
//   PRESCALE  2  clocks per decrement; legal range 1..2**8; a value of 1 means decrement every clock
// PORTS
//   clk       in   1      single clock; all state updates on the rising edge
//   rst       in   1      asynchronous, active-high reset
//   start     in   1      load request; sampled only in IDLE
//   load_val  in   WIDTH  preset value, captured on an accepted start
//   hold      in   1      pause: freezes the prescaler (del) and the count (q)
//   out       out  WIDTH  current count; a registered copy of internal q
//   tick      out  1      one-clock pulse on every decrement edge
//   busy      out  1      high while in RUN
//   done      out  1      one-clock pulse when the count reaches 0
// BEHAVIOUR
//   Reset (async, any state)
//     - state=IDLE; q=0; del=0; out=0; tick=0; busy=0; done=0.
//     - Applies immediately, including mid-RUN; any count in progress is discarded.
//   FSM states: IDLE, RUN, DONE.
//   IDLE
//     - start=1 and load_val!=0: next edge q=load_val, del=0, state RUN.
//     - start=1 and load_val==0: next edge state DONE; q stays 0.
//   RUN (busy=1)
//     - Prescaler: if hold=0, del increments, wrapping at PRESCALE-1 -> 0.
//     - Decrement edge = edge where del==PRESCALE-1 and hold=0:
//         q <= q-1; tick=1 for the following cycle.
//     - Decrement from q==1: q becomes 0 and state becomes DONE on the same edge.
//     - hold=1: del, q and state all frozen; tick=0.
//     - start is ignored; load_val is not re-sampled.
//   DONE
//     - done=1 for exactly one cycle; out=0; busy=0; then IDLE unconditionally.
//     - start during DONE is ignored; the earliest re-start is sampled in the following IDLE cycle.
//   Timing
//     - start accepted at edge E with load_val=N>0 and no hold.
//     - Decrements occur at edges E+k*P, k=1..N; out shows N-k after each one.
//     - done is high in the cycle after edge E+N*P; busy falls at that same edge.
//   Arithmetic: q is unsigned WIDTH bits and never underflows (a decrement only happens when q>=1).
//   tick and done are mutually exclusive except on the final decrement, where both go high in the same cycle.
// TESTING
//   1. Reset check: hold rst=1 for 10ns while clk runs, assert and release it mid-cycle
//      -> out=0, busy=0, done=0, tick=0 throughout reset.
//   2. Basic count (P=2): start with load_val=4
//      -> out goes 4,3,2,1,0, each step after 2 clocks; 4 tick pulses;
//         done pulses once 8 clocks after the start edge.
//   3. Zero load: start with load_val=0
//      -> no tick, busy stays 0, done pulses in the next cycle, out=0.
//   4. Hold: load_val=3, assert hold for 5 clocks after the first tick
//      -> out stays 2 during hold; done is delayed by exactly 5 clocks; tick=0 while held.
//   5. Ignored start: pulse start with load_val=9 during RUN and again during DONE
//      -> count is unaffected; the next IDLE start with load_val=15 counts down 15 -> 0.
//   6. Reset mid-RUN: load_val=15, assert rst when out=7
//      -> out=0 and busy=0 at once, no done pulse; a new start after release behaves as in test 2.

Source files
------------

// File: rtl/down_counter_if.sv
// Handshake and status bundle for the loadable prescaled down-counter.
interface down_counter_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] load_val;
  logic             hold;
  logic [WIDTH-1:0] out;
  logic             tick;
  logic             busy;
  logic             done;

  // The master drives the requests and observes the status.
  modport master (
    output start, load_val, hold,
    input  out, tick, busy, done
  );

  // The counter itself.
  modport slave (
    input  start, load_val, hold,
    output out, tick, busy, done
  );
endinterface

// File: rtl/down_counter_mod.sv
// Loadable down-counter with a prescaler. A start in IDLE captures a preset.
// The count then drops by one every PRESCALE clocks until it reaches zero,
// and done pulses for one cycle at that point.
module down_counter_mod #(
  parameter int WIDTH    = 4,
  parameter int PRESCALE = 2
) (
  input  logic               clk,
  input  logic               rst,
  down_counter_if.slave      bus
);
  // With PRESCALE==1 the prescaler still needs a 1-bit register. It stays at 0.
  localparam int DW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [DW-1:0] DEL_MAX = DW'(PRESCALE - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [DW-1:0]    del_q, del_d;
  logic [WIDTH-1:0] out_q;
  logic             tick_q;
  logic             dec;

  // State, count and prescaler registers. out and tick are registered copies of next-state values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      q_q     <= '0;
      del_q   <= '0;
      out_q   <= '0;
      tick_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      del_q   <= del_d;
      out_q   <= q_d;
      tick_q  <= dec;
    end
  end

  // Next-state logic: load on start, decrement on prescaler wrap, and finish when the count reaches 0.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    del_d   = del_q;
    dec     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          if (bus.load_val != '0) begin
            q_d     = bus.load_val;
            del_d   = '0;
            state_d = S_RUN;
          end else begin
            // A zero preset goes straight to DONE. q is already 0 in IDLE.
            state_d = S_DONE;
          end
        end
      end
      S_RUN: begin
        if (!bus.hold) begin
          if (del_q == DEL_MAX) begin
            del_d = '0;
            dec   = 1'b1;
            q_d   = q_q - 1'b1;
            if (q_q == WIDTH'(1)) state_d = S_DONE;
          end else begin
            del_d = del_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.out  = out_q;
  assign bus.tick = tick_q;
  assign bus.busy = (state_q == S_RUN);
  assign bus.done = (state_q == S_DONE);
endmodule

// File: tb/tb_down_counter_mod.sv
// Directed bench for down_counter_mod (WIDTH=4, PRESCALE=2).
module tb_down_counter_mod;
  localparam int W = 4;
  localparam int P = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  down_counter_if #(.WIDTH(W)) bus ();

  down_counter_mod #(.WIDTH(W), .PRESCALE(P)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Advance one rising edge. Sample and drive 1ns after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input int o, input int t, input int b, input int d);
    chk({tag, ".out"},  32'(bus.out),  32'(o));
    chk({tag, ".tick"}, 32'(bus.tick), 32'(t));
    chk({tag, ".busy"}, 32'(bus.busy), 32'(b));
    chk({tag, ".done"}, 32'(bus.done), 32'(d));
  endtask

  // Call this just after the start edge has been accepted with preset n and no hold.
  task automatic count_check(input string tag, input int n);
    chk_all({tag, ".load"}, n, 0, 1, 0);
    for (int k = 1; k <= n; k++) begin
      for (int j = 0; j < P - 1; j++) begin
        step();
        chk_all({tag, ".wait"}, n - k + 1, 0, 1, 0);
      end
      step();
      chk_all({tag, ".dec"}, n - k, 1, (k != n) ? 1 : 0, (k == n) ? 1 : 0);
    end
    step();
    chk_all({tag, ".idle"}, 0, 0, 0, 0);
  endtask

  initial begin
    bus.start    = 1'b0;
    bus.load_val = '0;
    bus.hold     = 1'b0;

    // Reset check: assert away from the edge and hold it for 10ns.
    #2 rst = 1'b1;
    #1 chk_all("rst_a", 0, 0, 0, 0);
    #4 chk_all("rst_b", 0, 0, 0, 0);
    #4 chk_all("rst_c", 0, 0, 0, 0);
    #1 rst = 1'b0;
    step();
    chk_all("post_rst", 0, 0, 0, 0);

    // Basic count from 4.
    bus.start = 1'b1; bus.load_val = 4'd4;
    step();
    bus.start = 1'b0;
    count_check("cnt4", 4);

    // Zero preset.
    bus.start = 1'b1; bus.load_val = 4'd0;
    step();
    bus.start = 1'b0;
    chk_all("zero.done", 0, 0, 0, 1);
    step();
    chk_all("zero.idle", 0, 0, 0, 0);

    // Hold for 5 clocks after the first tick.
    bus.start = 1'b1; bus.load_val = 4'd3;
    step();
    bus.start = 1'b0;
    chk_all("hold.load", 3, 0, 1, 0);
    step();
    chk_all("hold.w0", 3, 0, 1, 0);
    step();
    chk_all("hold.t1", 2, 1, 1, 0);
    bus.hold = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      chk_all("hold.frz", 2, 0, 1, 0);
    end
    bus.hold = 1'b0;
    step();
    chk_all("hold.w1", 2, 0, 1, 0);
    step();
    chk_all("hold.t2", 1, 1, 1, 0);
    step();
    chk_all("hold.w2", 1, 0, 1, 0);
    step();
    chk_all("hold.t3", 0, 1, 0, 1);
    step();
    chk_all("hold.idle", 0, 0, 0, 0);

    // A start in RUN or DONE is ignored. The next IDLE start loads 15.
    bus.start = 1'b1; bus.load_val = 4'd2;
    step();
    bus.load_val = 4'd9;
    chk_all("ign.load", 2, 0, 1, 0);
    step();
    chk_all("ign.run", 2, 0, 1, 0);
    bus.start = 1'b0;
    step();
    chk_all("ign.t1", 1, 1, 1, 0);
    step();
    chk_all("ign.w1", 1, 0, 1, 0);
    step();
    chk_all("ign.t2", 0, 1, 0, 1);
    bus.start = 1'b1; bus.load_val = 4'd9;
    step();
    chk_all("ign.done", 0, 0, 0, 0);
    bus.load_val = 4'd15;
    step();
    bus.start = 1'b0;
    count_check("cnt15", 15);

    // Reset in the middle of RUN when out is 7.
    bus.start = 1'b1; bus.load_val = 4'd15;
    step();
    bus.start = 1'b0;
    repeat (8 * P) step();
    chk_all("mid.pre", 7, 1, 1, 0);
    rst = 1'b1;
    #1 chk_all("mid.rst", 0, 0, 0, 0);
    step();
    chk_all("mid.rst2", 0, 0, 0, 0);
    #3 rst = 1'b0;
    step();
    chk_all("mid.rel", 0, 0, 0, 0);
    step();
    chk_all("mid.nodone", 0, 0, 0, 0);
    bus.start = 1'b1; bus.load_val = 4'd4;
    step();
    bus.start = 1'b0;
    count_check("cnt4b", 4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
